// File: rtl/puf_eval_controller_if.sv
// ----------------------------------------------------------------------------
// puf_eval_controller_if
// Host-side bus of the PUF evaluation controller: the request handshake
// (start / busy / done), the challenge and PDL configuration to evaluate,
// and the voted result.
//   master : host side   - drives start, challenge_in, pdl_config_in
//   slave  : controller  - drives busy, done, response, xor_response,
//                          unstable_mask
// ----------------------------------------------------------------------------
interface puf_eval_controller_if #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 128,
    parameter int RESPONSE_WIDTH   = 6
);
    logic                        start;
    logic [CHALLENGE_WIDTH-1:0]  challenge_in;
    logic [PDL_CONFIG_WIDTH-1:0] pdl_config_in;
    logic                        busy;
    logic                        done;
    logic [RESPONSE_WIDTH-1:0]   response;
    logic                        xor_response;
    logic [RESPONSE_WIDTH-1:0]   unstable_mask;

    modport master (
        output start, challenge_in, pdl_config_in,
        input  busy, done, response, xor_response, unstable_mask
    );

    modport slave (
        input  start, challenge_in, pdl_config_in,
        output busy, done, response, xor_response, unstable_mask
    );
endinterface

// File: rtl/puf_eval_controller.sv
// ----------------------------------------------------------------------------
// puf_eval_controller
// Drives an arbiter PUF through EVAL_COUNT reset/launch/sample evaluations
// for one challenge and majority-votes each response bit.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   host            : slave modport of puf_eval_controller_if (request/result)
//   raw_response    : raw PUF response bits, sampled once per evaluation
//   puf_challenge   : latched challenge to the PUF
//   puf_pdl_config  : latched PDL configuration to the PUF
//   puf_reset       : arbiter reset (high while idle and in the reset phase)
//   puf_trigger     : launch edge (high during the settle phase)
// All outputs are registered; they are computed from the next state.
// ----------------------------------------------------------------------------
module puf_eval_controller #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 128,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int RST_CYCLES       = 2,
    parameter int SETTLE_CYCLES    = 8,
    parameter int EVAL_COUNT       = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    puf_eval_controller_if.slave        host,
    input  logic [RESPONSE_WIDTH-1:0]   raw_response,
    output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
    output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
    output logic                        puf_reset,
    output logic                        puf_trigger
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRST   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // Phase counter only needs to reach max(RST_CYCLES, SETTLE_CYCLES)-1.
    localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [2:0]                         state_q, state_d;
    logic [CW-1:0]                      cyc_q, cyc_d;
    logic [3:0]                         eval_q, eval_d;
    logic [RESPONSE_WIDTH-1:0][3:0]     ones_q, ones_d;
    logic [CHALLENGE_WIDTH-1:0]         chal_q, chal_d;
    logic [PDL_CONFIG_WIDTH-1:0]        pdl_q, pdl_d;
    logic [RESPONSE_WIDTH-1:0]          resp_q, resp_d;
    logic [RESPONSE_WIDTH-1:0]          mask_q, mask_d;
    logic                               xor_q, xor_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               prst_q, prst_d;
    logic                               trig_q, trig_d;

    // Next-state, counter and result computation.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        chal_d  = chal_q;
        pdl_d   = pdl_q;
        resp_d  = resp_q;
        mask_d  = mask_q;
        xor_d   = xor_q;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    chal_d  = host.challenge_in;
                    pdl_d   = host.pdl_config_in;
                    eval_d  = 4'd0;
                    ones_d  = '0;
                    cyc_d   = '0;
                    state_d = PRST;
                end else begin
                    state_d = IDLE;
                end
            end
            PRST: begin
                if (cyc_q == CW'(RST_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cyc_d   = cyc_q + CW'(1);
                end
            end
            SETTLE: begin
                if (cyc_q == CW'(SETTLE_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cyc_d   = cyc_q + CW'(1);
                end
            end
            SAMPLE: begin
                for (int i = 0; i < RESPONSE_WIDTH; i++) begin
                    ones_d[i] = ones_q[i] + {3'b000, raw_response[i]};
                end
                if (eval_q == 4'(EVAL_COUNT - 1)) begin
                    // Vote on the counts including this last sample so the
                    // result is already registered when done rises.
                    for (int i = 0; i < RESPONSE_WIDTH; i++) begin
                        resp_d[i] = (ones_d[i] > 4'(EVAL_COUNT / 2));
                        mask_d[i] = (ones_d[i] != 4'd0) && (ones_d[i] != 4'(EVAL_COUNT));
                    end
                    xor_d   = ^resp_d;
                    state_d = DONE;
                end else begin
                    eval_d  = eval_q + 4'd1;
                    state_d = PRST;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        // Arbiter is held in reset while idle as well as in the reset phase.
        prst_d = (state_d == PRST) || (state_d == IDLE);
        trig_d = (state_d == SETTLE);
    end

    // State and registered outputs; reset aborts any run without a done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            eval_q  <= 4'd0;
            ones_q  <= '0;
            chal_q  <= '0;
            pdl_q   <= '0;
            resp_q  <= '0;
            mask_q  <= '0;
            xor_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prst_q  <= 1'b1;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            eval_q  <= eval_d;
            ones_q  <= ones_d;
            chal_q  <= chal_d;
            pdl_q   <= pdl_d;
            resp_q  <= resp_d;
            mask_q  <= mask_d;
            xor_q   <= xor_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prst_q  <= prst_d;
            trig_q  <= trig_d;
        end
    end

    assign host.busy          = busy_q;
    assign host.done          = done_q;
    assign host.response      = resp_q;
    assign host.xor_response  = xor_q;
    assign host.unstable_mask = mask_q;
    assign puf_challenge      = chal_q;
    assign puf_pdl_config     = pdl_q;
    assign puf_reset          = prst_q;
    assign puf_trigger        = trig_q;
endmodule

// File: tb/tb_puf_eval_controller.sv
// ----------------------------------------------------------------------------
// tb_puf_eval_controller
// Directed bench: dut_a uses R=2, S=4, N=5 (done 36 cycles after accept);
// dut_b uses R=1, S=1, N=1 (done 4 cycles after accept). Cycle c means the
// c-th clock period after the accepting edge; outputs are sampled 1 time
// unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_puf_eval_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [5:0]   raw_a, raw_b;
    logic [63:0]  chal_a, chal_b;
    logic [127:0] pdl_a, pdl_b;
    logic         pr_a, pt_a, pr_b, pt_b;

    puf_eval_controller_if #(.CHALLENGE_WIDTH(64), .PDL_CONFIG_WIDTH(128), .RESPONSE_WIDTH(6)) if_a ();
    puf_eval_controller_if #(.CHALLENGE_WIDTH(64), .PDL_CONFIG_WIDTH(128), .RESPONSE_WIDTH(6)) if_b ();

    puf_eval_controller #(.CHALLENGE_WIDTH(64), .PDL_CONFIG_WIDTH(128), .RESPONSE_WIDTH(6),
                          .RST_CYCLES(2), .SETTLE_CYCLES(4), .EVAL_COUNT(5)) dut_a (
        .clk(clk), .reset(reset), .host(if_a), .raw_response(raw_a),
        .puf_challenge(chal_a), .puf_pdl_config(pdl_a),
        .puf_reset(pr_a), .puf_trigger(pt_a)
    );

    puf_eval_controller #(.CHALLENGE_WIDTH(64), .PDL_CONFIG_WIDTH(128), .RESPONSE_WIDTH(6),
                          .RST_CYCLES(1), .SETTLE_CYCLES(1), .EVAL_COUNT(1)) dut_b (
        .clk(clk), .reset(reset), .host(if_b), .raw_response(raw_b),
        .puf_challenge(chal_b), .puf_pdl_config(pdl_b),
        .puf_reset(pr_b), .puf_trigger(pt_b)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] raw_vec [5];
    int         dc, dn;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dut_a run; raw_vec[k] is presented in the SAMPLE cycle 7*(k+1),
    // the inverse of the next vector elsewhere so mistimed sampling shows up.
    task automatic run_main(input logic [63:0] chal, input logic [127:0] pdl,
                            input int restart_at, input logic [5:0] prev_resp,
                            output int done_cyc, output int done_cnt);
        if_a.start         = 1'b1;
        if_a.challenge_in  = chal;
        if_a.pdl_config_in = pdl;
        raw_a              = 6'b000000;
        tick();
        done_cyc = -1;
        done_cnt = 0;
        for (int c = 1; c <= 45; c++) begin
            if ((c % 7 == 0) && (c <= 35)) raw_a = raw_vec[c / 7 - 1];
            else                           raw_a = ~raw_vec[(c / 7) % 5];
            if (c == restart_at) begin
                if_a.start        = 1'b1;
                if_a.challenge_in = ~chal;
            end else begin
                if_a.start        = 1'b0;
                if_a.challenge_in = chal;
            end
            if (c == 1) begin
                check("prst_reset", pr_a, 1'b1);
                check("prst_trig", pt_a, 1'b0);
                check("busy_run", if_a.busy, 1'b1);
                check("chal_latch", chal_a, chal);
                check("pdl_latch", pdl_a, pdl);
                check("resp_hold", if_a.response, prev_resp);
            end
            if (c == 2)  check("prst_len", pr_a, 1'b1);
            if (c == 3)  check("settle_trig", {pr_a, pt_a}, 2'b01);
            if (c == 6)  check("settle_len", pt_a, 1'b1);
            if (c == 7)  check("sample_pins", {pr_a, pt_a}, 2'b00);
            if (c == 20) check("chal_hold", chal_a, chal);
            if (c == 37) check("idle_after", {if_a.busy, pr_a}, 2'b01);
            if (if_a.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            tick();
        end
    endtask

    initial begin
        reset              = 1'b1;
        if_a.start         = 1'b0;
        if_a.challenge_in  = 64'h0;
        if_a.pdl_config_in = 128'h0;
        if_b.start         = 1'b0;
        if_b.challenge_in  = 64'h0;
        if_b.pdl_config_in = 128'h0;
        raw_a              = 6'b000000;
        raw_b              = 6'b000000;
        tick();
        tick();
        check("rst_busy", if_a.busy, 1'b0);
        check("rst_done", if_a.done, 1'b0);
        check("rst_pins", {pr_a, pt_a}, 2'b10);
        check("rst_resp", {if_a.response, if_a.unstable_mask, if_a.xor_response}, 13'h0);
        check("rst_chal", chal_a, 64'h0);
        reset = 1'b0;
        tick();
        check("idle_prst", {if_a.busy, pr_a, pt_a}, 3'b010);

        // Stable response on every evaluation.
        raw_vec = '{6'b101101, 6'b101101, 6'b101101, 6'b101101, 6'b101101};
        run_main(64'hDEADBEEF01234567, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, -1, 6'b000000, dc, dn);
        check("t1_done_cyc", dc, 36);
        check("t1_done_cnt", dn, 1);
        check("t1_resp", if_a.response, 6'b101101);
        check("t1_xor", if_a.xor_response, 1'b0);
        check("t1_mask", if_a.unstable_mask, 6'b000000);

        // Split votes on bits 0/1, plus an ignored start at cycle 10.
        raw_vec = '{6'b000001, 6'b000001, 6'b000000, 6'b000010, 6'b000011};
        run_main(64'h0123456789ABCDEF, 128'h1, 10, 6'b101101, dc, dn);
        check("t2_done_cyc", dc, 36);
        check("t2_done_cnt", dn, 1);
        check("t2_resp", if_a.response, 6'b000001);
        check("t2_xor", if_a.xor_response, 1'b1);
        check("t2_mask", if_a.unstable_mask, 6'b000011);

        // Mixed pattern: per-bit ones 5,3,3,2,2,2 (bit5..bit0).
        raw_vec = '{6'b111000, 6'b110100, 6'b101010, 6'b100001, 6'b111111};
        run_main(64'hFEDCBA9876543210, 128'h2, -1, 6'b000001, dc, dn);
        check("t3_resp", if_a.response, 6'b111000);
        check("t3_xor", if_a.xor_response, 1'b1);
        check("t3_mask", if_a.unstable_mask, 6'b011111);

        // Reset during the third evaluation's settle phase (cycles 17..20).
        if_a.start        = 1'b1;
        if_a.challenge_in = 64'h5555AAAA5555AAAA;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c < 18; c++) tick();
        check("mid_settle", pt_a, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", {if_a.busy, if_a.done, pt_a, pr_a}, 4'b0001);
        check("abort_resp", {if_a.response, if_a.unstable_mask, if_a.xor_response}, 13'h0);
        check("abort_chal", chal_a, 64'h0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (if_a.done) dn++;
            tick();
        end
        check("abort_no_done", dn, 0);

        // Reset wins over start in the same cycle.
        reset      = 1'b1;
        if_a.start = 1'b1;
        tick();
        reset      = 1'b0;
        if_a.start = 1'b0;
        check("rst_dom_start", if_a.busy, 1'b0);
        tick();
        check("rst_dom_idle", if_a.busy, 1'b0);

        // start held high: runs back to back, each re-latching challenge_in.
        raw_a             = 6'b011011;
        if_a.start        = 1'b1;
        if_a.challenge_in = 64'h1111111111111111;
        tick();
        dc = -1;
        dn = -1;
        for (int c = 1; c <= 80; c++) begin
            if (c >= 5) if_a.challenge_in = 64'h2222222222222222;
            if (c == 20) check("b2b_chal1", chal_a, 64'h1111111111111111);
            if (c == 38) check("b2b_chal2", chal_a, 64'h2222222222222222);
            if (if_a.done) begin
                if (dc < 0) begin
                    dc = c;
                    check("b2b_resp", if_a.response, 6'b011011);
                end else if (dn < 0) begin
                    dn = c;
                end
            end
            tick();
        end
        if_a.start = 1'b0;
        check("b2b_done1", dc, 36);
        check("b2b_done2", dn, 73);

        // Minimal configuration on dut_b: PRST, SETTLE, SAMPLE, DONE.
        if_b.start         = 1'b1;
        if_b.challenge_in  = 64'hCAFEF00DCAFEF00D;
        if_b.pdl_config_in = 128'h7;
        raw_b              = 6'b101001;
        tick();
        if_b.start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 6; c++) begin
            raw_b = (c == 3) ? 6'b010110 : 6'b101001;
            if (c == 1) check("b_prst", {pr_b, pt_b}, 2'b10);
            if (c == 2) check("b_settle", {pr_b, pt_b}, 2'b01);
            if (c == 3) check("b_sample", {pr_b, pt_b}, 2'b00);
            if (if_b.done && dc < 0) begin
                dc = c;
                check("b_resp", if_b.response, 6'b010110);
                check("b_mask", if_b.unstable_mask, 6'b000000);
                check("b_xor", if_b.xor_response, 1'b1);
            end
            tick();
        end
        check("b_done_cyc", dc, 4);
        check("b_idle", if_b.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
